regfile_param: RTL and testbench



---
 rtl/regfile_param_if.sv | 27 ++
 rtl/regfile_param.sv | 102 ++++++++++
 tb/tb_regfile_param.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Port bundle for regfile_param: write port, two read ports, clear request and busy.
// The datapath side drives through master; the register file itself uses slave.
interface regfile_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                  clr;
    logic                  we;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wbe;
    logic [ADDR_W-1:0]     raddr1;
    logic [ADDR_W-1:0]     raddr2;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic                  busy;

    modport master (
        output clr, we, waddr, wdata, wbe, raddr1, raddr2,
        input  rdata1, rdata2, busy
    );

    modport slave (
        input  clr, we, waddr, wdata, wbe, raddr1, raddr2,
        output rdata1, rdata2, busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with byte enables, optional bypass,
// optional hardwired zero entry and a sequential clear engine.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("regfile_param: DATA_W must be a multiple of 8");
    end

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              busy_q;
    logic              wr_eff;
    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        return res;
    endfunction

    // clr wins over a same-cycle write, and entry 0 never takes a datapath write.
    assign wr_eff = bus.we && (state == S_IDLE) && !bus.clr &&
                    !((ZERO_REG != 0) && (bus.waddr == '0));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_CLEAR;
            ptr    <= '0;
            busy_q <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        ptr    <= '0;
                    end
                end
                default: begin
                    if (bus.clr) begin
                        state  <= S_CLEAR;
                        busy_q <= 1'b1;
                        ptr    <= '0;
                    end
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset; the clear engine zeroes it one
    // entry per cycle, which keeps it mappable onto RAM/latch-array macros.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_eff) begin
                for (int i = 0; i < NB; i++)
                    if (bus.wbe[i]) mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        bus.rdata1 = mem[bus.raddr1];
        if ((BYPASS != 0) && wr_eff && (bus.waddr == bus.raddr1))
            bus.rdata1 = merge(mem[bus.raddr1], bus.wdata, bus.wbe);
        if (busy_q || ((ZERO_REG != 0) && (bus.raddr1 == '0)))
            bus.rdata1 = '0;
    end

    always_comb begin
        bus.rdata2 = mem[bus.raddr2];
        if ((BYPASS != 0) && wr_eff && (bus.waddr == bus.raddr2))
            bus.rdata2 = merge(mem[bus.raddr2], bus.wdata, bus.wbe);
        if (busy_q || ((ZERO_REG != 0) && (bus.raddr2 == '0)))
            bus.rdata2 = '0;
    end

    assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (zero-reg+bypass, and neither) driven in
// lockstep with directed tables, clear-timing sequences and a random model check.
module tb_regfile_param;
    logic clk;
    logic rst;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: config 0 = zero-reg + bypass, config 1 = plain.
    logic [31:0] mem_m [2][32];
    bit          busy_m [2];
    int          cnt_m [2];
    bit          zr_m [2]  = '{1'b1, 1'b0};
    bit          byp_m [2] = '{1'b1, 1'b0};

    function automatic bit eff_m(int c);
        return bus_a.we && !busy_m[c] && !bus_a.clr && !(zr_m[c] && bus_a.waddr == 0);
    endfunction

    function automatic logic [31:0] merged_m(logic [31:0] old_w);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (bus_a.wbe[i]) r[8*i +: 8] = bus_a.wdata[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] pred(int c, logic [4:0] a);
        if (busy_m[c]) return 32'h0;
        if (zr_m[c] && a == 0) return 32'h0;
        if (byp_m[c] && eff_m(c) && bus_a.waddr == a) return merged_m(mem_m[c][a]);
        return mem_m[c][a];
    endfunction

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                busy_m[c] = 1'b1;
                cnt_m[c]  = 0;
            end else if (busy_m[c]) begin
                cnt_m[c]++;
                if (cnt_m[c] == 32) begin
                    busy_m[c] = 1'b0;
                    for (int e = 0; e < 32; e++) mem_m[c][e] = 32'h0;
                end
            end else if (bus_a.clr) begin
                busy_m[c] = 1'b1;
                cnt_m[c]  = 0;
            end else if (eff_m(c)) begin
                mem_m[c][bus_a.waddr] = merged_m(mem_m[c][bus_a.waddr]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [3:0] be, input logic [4:0] r1, input logic [4:0] r2,
                          input logic c);
        bus_a.we = we; bus_a.waddr = wa; bus_a.wdata = wd; bus_a.wbe = be;
        bus_a.raddr1 = r1; bus_a.raddr2 = r2; bus_a.clr = c;
        bus_b.we = we; bus_b.waddr = wa; bus_b.wdata = wd; bus_b.wbe = be;
        bus_b.raddr1 = r1; bus_b.raddr2 = r2; bus_b.clr = c;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_a_r1"}, bus_a.rdata1, pred(0, bus_a.raddr1));
        check({tag, "_a_r2"}, bus_a.rdata2, pred(0, bus_a.raddr2));
        check({tag, "_a_busy"}, {31'b0, bus_a.busy}, {31'b0, busy_m[0]});
        check({tag, "_b_r1"}, bus_b.rdata1, pred(1, bus_b.raddr1));
        check({tag, "_b_r2"}, bus_b.rdata2, pred(1, bus_b.raddr2));
        check({tag, "_b_busy"}, {31'b0, bus_b.busy}, {31'b0, busy_m[1]});
    endtask

    // Count edges until both instances leave CLEAR; optional second clr at edge 5.
    task automatic wait_clear(input string tag, input bit reclr);
        int na, nb, n;
        na = 0; nb = 0; n = 0;
        while ((na == 0 || nb == 0) && n < 100) begin
            set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9, reclr && n == 5);
            step();
            n++;
            if (na == 0 && !bus_a.busy) na = n;
            if (nb == 0 && !bus_b.busy) nb = n;
        end
        check({tag, "_len_a"}, na, 32);
        check({tag, "_len_b"}, nb, 32);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic [4:0]  r1, r2;
        logic [31:0] ea1, ea2, eb1, eb2;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b1, 5'd7, 32'h12345678, 4'hF, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[2] = '{1'b1, 5'd3, 32'hAABBCCDD, 4'hF, 5'd3, 5'd7, 32'hAABBCCDD, 32'h12345678, 32'h0, 32'h12345678};
        vecs[3] = '{1'b1, 5'd3, 32'h11223344, 4'h5, 5'd3, 5'd3, 32'hAA22CC44, 32'hAA22CC44, 32'hAABBCCDD, 32'hAABBCCDD};
        vecs[4] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd0, 32'hAA22CC44, 32'h0, 32'hAA22CC44, 32'h0};
        vecs[5] = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[7] = '{1'b1, 5'd5, 32'h55555555, 4'h0, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0, 32'h0};

        for (int c = 0; c < 2; c++) begin
            busy_m[c] = 1'b1;
            cnt_m[c]  = 0;
            for (int e = 0; e < 32; e++) mem_m[c][e] = 32'h0;
        end

        // Reset held 3 cycles: busy high, reads zero.
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_busy_a", {31'b0, bus_a.busy}, 32'h1);
            check("rst_busy_b", {31'b0, bus_b.busy}, 32'h1);
            check("rst_rd1_a", bus_a.rdata1, 32'h0);
            check("rst_rd2_b", bus_b.rdata2, 32'h0);
        end
        rst = 1'b0;

        // Clear after reset, with writes attempted throughout.
        begin
            int na, nb, n;
            na = 0; nb = 0; n = 0;
            while ((na == 0 || nb == 0) && n < 100) begin
                set_in(1'b1, 5'(n), 32'hFFFFFFFF, 4'hF, 5'(n), 5'(n), 1'b0);
                #1;
                if (na == 0) check("busy_rd_a", bus_a.rdata1, 32'h0);
                if (nb == 0) check("busy_rd_b", bus_b.rdata2, 32'h0);
                step();
                n++;
                if (na == 0 && !bus_a.busy) na = n;
                if (nb == 0 && !bus_b.busy) nb = n;
            end
            check("reset_clear_len_a", na, 32);
            check("reset_clear_len_b", nb, 32);
        end

        for (int i = 0; i < 32; i++) begin
            set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i), 1'b0);
            #1;
            check($sformatf("sweep_a_r1[%0d]", i), bus_a.rdata1, 32'h0);
            check($sformatf("sweep_a_r2[%0d]", i), bus_a.rdata2, 32'h0);
            check($sformatf("sweep_b_r1[%0d]", i), bus_b.rdata1, 32'h0);
            check($sformatf("sweep_b_r2[%0d]", i), bus_b.rdata2, 32'h0);
        end

        // Directed write/read, byte enable and zero-register table.
        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].wbe, vecs[i].r1, vecs[i].r2, 1'b0);
            #1;
            check($sformatf("vec%0d_a_r1", i), bus_a.rdata1, vecs[i].ea1);
            check($sformatf("vec%0d_a_r2", i), bus_a.rdata2, vecs[i].ea2);
            check($sformatf("vec%0d_b_r1", i), bus_b.rdata1, vecs[i].eb1);
            check($sformatf("vec%0d_b_r2", i), bus_b.rdata2, vecs[i].eb2);
            step();
        end

        // clr colliding with a write, second clr during CLEAR.
        set_in(1'b1, 5'd9, 32'hDEAD0009, 4'hF, 5'd9, 5'd9, 1'b0);
        step();
        set_in(1'b1, 5'd9, 32'h5, 4'hF, 5'd9, 5'd9, 1'b1);
        #1;
        check("coll_nobyp_a", bus_a.rdata1, 32'hDEAD0009);
        check("coll_nobyp_b", bus_b.rdata1, 32'hDEAD0009);
        step();
        check("coll_busy_a", {31'b0, bus_a.busy}, 32'h1);
        check("coll_busy_b", {31'b0, bus_b.busy}, 32'h1);
        wait_clear("clr", 1'b1);
        set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd9, 1'b0);
        #1;
        check("coll_e9_a", bus_a.rdata1, 32'h0);
        check("coll_e9_b", bus_b.rdata2, 32'h0);

        // Reset at ptr=10 restarts a full clear.
        set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b1);
        step();
        set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_clear("midrst", 1'b0);

        // Dual-port read of the address being written.
        set_in(1'b1, 5'd4, 32'hCAFEF00D, 4'hF, 5'd4, 5'd4, 1'b0);
        #1;
        check("dual_byp_a_r1", bus_a.rdata1, 32'hCAFEF00D);
        check("dual_byp_a_r2", bus_a.rdata2, 32'hCAFEF00D);
        check("dual_nobyp_b_r1", bus_b.rdata1, 32'h0);
        check("dual_nobyp_b_r2", bus_b.rdata2, 32'h0);
        step();
        set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd4, 1'b0);
        #1;
        check("dual_after_a", bus_a.rdata2, 32'hCAFEF00D);
        check("dual_after_b_r1", bus_b.rdata1, 32'hCAFEF00D);
        check("dual_after_b_r2", bus_b.rdata2, 32'hCAFEF00D);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic        r_we, r_clr;
            logic [4:0]  wa, ra1, ra2;
            rst   = ($urandom_range(0, 249) == 0);
            r_clr = ($urandom_range(0, 79) == 0);
            r_we  = rst ? 1'b0 : ($urandom_range(0, 2) != 0);
            wa    = 5'($urandom_range(0, 31));
            ra1   = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2   = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            set_in(r_we, wa, $urandom, 4'($urandom_range(0, 15)), ra1, ra2, r_clr);
            #1;
            check_model($sformatf("rnd%0d", i));
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
